// File: rtl/intf_array_rr_arb.sv
//------------------------------------------------------------------------------
// intf_array_rr_arb
//   N-channel round-robin arbiter merging NCH valid/ready streams into a single
//   registered output beat. Optional packet lock: INTF_ARB_PKT_LOCK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module intf_array_rr_arb #(
  parameter  int NCH = 4,
  parameter  int DW  = 8,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_chan,
  input  logic              out_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CW:0]   NCH_W  = (CW+1)'(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  state_t          state_q;
  logic [DW-1:0]   out_data_q;
  logic [CW-1:0]   out_chan_q;
  logic [CW-1:0]   ptr_q;

  logic            w_load;
  logic            w_found;
  logic            w_xfer;
  logic [NCH-1:0]  w_grant;
  logic [CW-1:0]   w_gidx;
  logic [CW-1:0]   w_ptr_nxt;
  logic [DW-1:0]   w_sel_data;
  logic [DW-1:0]   w_masked [NCH];

`ifdef INTF_ARB_PKT_LOCK_EN
  logic            lock_q;
`else
  logic            w_unused_last;
  assign w_unused_last = ^in_last;
`endif

  assign w_load = (state_q == ST_EMPTY) || out_ready;

  // Rotating-priority search starting at ptr_q; first valid channel wins.
  always_comb begin
    logic [CW:0] idx;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr_q} + (CW+1)'(k);
      if (idx >= NCH_W) begin
        idx = idx - NCH_W;
      end
      if (!w_found && in_valid[idx[CW-1:0]]) begin
        w_found                 = 1'b1;
        w_gidx                  = idx[CW-1:0];
        w_grant[idx[CW-1:0]]    = 1'b1;
      end
    end
`ifdef INTF_ARB_PKT_LOCK_EN
    // While a packet is open only its source may be granted, even if idle.
    // out_chan_q always holds the channel of the most recent transfer.
    if (lock_q) begin
      w_grant             = '0;
      w_gidx              = out_chan_q;
      w_found             = in_valid[out_chan_q];
      w_grant[out_chan_q] = in_valid[out_chan_q];
    end
`endif
  end

  assign w_xfer    = w_found && w_load;
  assign in_ready  = w_grant & {NCH{w_load}};
  assign w_ptr_nxt = (w_gidx == LAST_CH) ? '0 : w_gidx + 1'b1;

  // Masking by grant keeps unsampled (possibly X) channel data off the mux.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_masked[i] = in_data[i*DW +: DW] & {DW{w_grant[i]}};
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sel_data = w_sel_data | w_masked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= '0;
`ifdef INTF_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_xfer) begin
        state_q    <= ST_FULL;
        out_data_q <= w_sel_data;
        out_chan_q <= w_gidx;
`ifdef INTF_ARB_PKT_LOCK_EN
        if (in_last[w_gidx]) begin
          lock_q <= 1'b0;
          ptr_q  <= w_ptr_nxt;
        end else begin
          lock_q <= 1'b1;
        end
`else
        ptr_q      <= w_ptr_nxt;
`endif
      end else begin
        state_q <= ST_EMPTY;
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_intf_array_rr_arb.sv
//------------------------------------------------------------------------------
// tb_intf_array_rr_arb
//   Directed self-checking bench for intf_array_rr_arb (NCH=4, DW=8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_intf_array_rr_arb;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_last;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intf_array_rr_arb #(.NCH(NCH), .DW(DW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] chdat [NCH];
  int         exp_seq [4];
  int         cnt1;

  initial begin
    chdat[0] = 8'h10; chdat[1] = 8'h21; chdat[2] = 8'h32; chdat[3] = 8'h43;
    rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_chan",  32'(out_chan),  32'd0);
    rst_n = 1'b1;

    // idle
    repeat (10) tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready),  32'h0);
    check("idle_data",  32'(out_data),  32'h00);

    // all channels valid: fair rotation 0..3
    in_data  = {chdat[3], chdat[2], chdat[1], chdat[0]};
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_ready%0d", i), 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      check($sformatf("rr_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("rr_chan%0d", i),  32'(out_chan),  32'(i % 4));
      check($sformatf("rr_data%0d", i),  32'(out_data),  32'(chdat[i % 4]));
    end

    // ch1 alone moves ptr to 2, then only ch1/ch3 valid: 3,1,3
    in_valid = 4'b0010;
    tick();
    check("p2_chan", 32'(out_chan), 32'd1);
    in_valid = 4'b1010;
    exp_seq = '{3, 1, 3, 0};
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sp_chan%0d", i), 32'(out_chan), 32'(exp_seq[i]));
      check($sformatf("sp_data%0d", i), 32'(out_data), 32'(chdat[exp_seq[i]]));
    end

    // backpressure with ch2 carrying 0x55 (ptr now 0)
    in_data[2*DW +: DW] = 8'h55;
    in_valid = 4'b0100;
    tick();
    check("bp_load_chan", 32'(out_chan), 32'd2);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_chan%0d", i),  32'(out_chan),  32'd2);
      check($sformatf("bp_data%0d", i),  32'(out_data),  32'h55);
      check($sformatf("bp_ready%0d", i), 32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(in_ready), 32'b1000);
    tick();
    check("bp_rel_chan", 32'(out_chan), 32'd3);
    check("bp_rel_data", 32'(out_data), 32'h43);

    // asynchronous reset while FULL
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_chan",  32'(out_chan),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_data[2*DW +: DW] = chdat[2];
    #1;
    check("ar_ready", 32'(in_ready), 32'b0001);
    tick();
    check("ar_chan0", 32'(out_chan), 32'd0);
    check("ar_data0", 32'(out_data), 32'h10);

    // packet: ptr=1, ch1 sends 3 beats, ch0 always valid
`ifdef INTF_ARB_PKT_LOCK_EN
    exp_seq = '{1, 1, 1, 0};
`else
    exp_seq = '{1, 0, 1, 0};
`endif
    cnt1     = 0;
    in_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      in_last = {2'b00, (cnt1 == 2), 1'b1};
      #1;
      check($sformatf("pk_ready%0d", i), 32'(in_ready), 32'(1 << exp_seq[i]));
      tick();
      check($sformatf("pk_chan%0d", i), 32'(out_chan), 32'(exp_seq[i]));
      check($sformatf("pk_data%0d", i), 32'(out_data), 32'(chdat[exp_seq[i]]));
      if (exp_seq[i] == 1) cnt1++;
    end

    in_valid = '0;
    tick();
    check("end_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
